nibble_serial_csel_adder: RTL

//   Multi-cycle wide adder that feeds the 4-bit carry-select adder slice one nibble per cycle.

---
 rtl/nibble_serial_csel_adder.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/nibble_serial_csel_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_csel_adder
//   Multi-cycle wide unsigned adder built around a single 4-bit carry-select
//   slice. Operands are taken over a valid/ready handshake. The operands are
//   added one nibble per cycle, starting at nibble 0, with the carry kept in a
//   register between nibbles. The result is then offered over a valid/ready
//   handshake and held until the sink takes it.
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   in_valid   operand request valid
//   in_ready   block can accept operands (high only while idle)
//   a, b       WIDTH-bit operands, sampled on in_valid & in_ready
//   Cin        carry-in, sampled together with a/b
//   out_valid  Sum/Cout valid (high only while the result is held)
//   out_ready  sink accepts the result
//   Sum        registered result a+b+Cin, mod 2^WIDTH
//   Cout       carry out of bit WIDTH-1
//   ovf        (only with OVERFLOW_DETECT_EN) signed two's-complement overflow
//
// Build option
//   OVERFLOW_DETECT_EN : adds the registered `ovf` output.
// -----------------------------------------------------------------------------
module nibble_serial_csel_adder #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             Cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
`ifdef OVERFLOW_DETECT_EN
  ,
  output logic             ovf
`endif
);

  localparam int NIB_CNT = WIDTH / 4;
  localparam int IDX_W   = (NIB_CNT > 1) ? $clog2(NIB_CNT) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);
  localparam logic [IDX_W-1:0] IDX_ZERO = IDX_W'(0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // One carry-select slice: both carry cases are formed up front and the
  // registered carry picks one. Result is {carry_out, sum[3:0]}.
  function automatic logic [4:0] csel_nibble(input logic [3:0] x,
                                             input logic [3:0] y,
                                             input logic       c);
    logic [4:0] s0;
    logic [4:0] s1;
    s0 = {1'b0, x} + {1'b0, y};
    s1 = s0 + 5'd1;
    if (c) begin
      return s1;
    end else begin
      return s0;
    end
  endfunction

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               carry_q, carry_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               cout_q, cout_d;
  logic [4:0]         nib_res_s;
`ifdef OVERFLOW_DETECT_EN
  logic               ovf_q, ovf_d;
`endif

  // Next-state logic. The latched operands are shifted right one nibble per
  // RUN cycle so the slice always sees bits [3:0]; result nibbles enter Sum
  // at the top and reach their final position after NIB_CNT shifts.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    carry_d   = carry_q;
    a_d       = a_q;
    b_d       = b_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
`ifdef OVERFLOW_DETECT_EN
    ovf_d     = ovf_q;
`endif
    nib_res_s = csel_nibble(a_q[3:0], b_q[3:0], carry_q);

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = Cin;
          idx_d   = IDX_ZERO;
          sum_d   = {WIDTH{1'b0}};
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = {4'h0, a_q[WIDTH-1:4]};
        b_d     = {4'h0, b_q[WIDTH-1:4]};
        sum_d   = {nib_res_s[3:0], sum_q[WIDTH-1:4]};
        carry_d = nib_res_s[4];
        if (idx_q == LAST_IDX) begin
          idx_d   = IDX_ZERO;
          cout_d  = nib_res_s[4];
`ifdef OVERFLOW_DETECT_EN
          // Carry into the MSB is recovered from the MSB sum bit.
          ovf_d   = (a_q[3] ^ b_q[3] ^ nib_res_s[3]) ^ nib_res_s[4];
`endif
          state_d = ST_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_ZERO;
      carry_q <= 1'b0;
      a_q     <= {WIDTH{1'b0}};
      b_q     <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cout_q  <= 1'b0;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
`ifdef OVERFLOW_DETECT_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign Sum       = sum_q;
  assign Cout      = cout_q;
`ifdef OVERFLOW_DETECT_EN
  assign ovf       = ovf_q;
`endif

endmodule
